// File: rtl/ibex_load_decrypt_pkg.sv
// Shared definitions for the load-side memory decryptor.
// Holds the cipher parameters shared with the store-side encryptor, the
// decryptor FSM state type, and the round functions. Encrypt and decrypt rounds
// live side by side so that they stay exact inverses of each other.
package ibex_load_decrypt_pkg;

  parameter int unsigned MEM_CRYPT_ROUNDS = 4;
  parameter int unsigned MEM_CRYPT_ROT    = 7;

  typedef enum logic [1:0] {
    DEC_IDLE  = 2'd0,
    DEC_ROUND = 2'd1,
    DEC_DONE  = 2'd2
  } dec_state_e;

  // 32-bit rotate left. A zero amount yields x >> 32 == 0, so the OR returns x.
  function automatic logic [31:0] crypt_rotl(input logic [31:0] x, input logic [4:0] amt);
    logic [5:0] inv;
    inv = 6'd32 - {1'b0, amt};
    return (x << amt) | (x >> inv);
  endfunction

  // 32-bit rotate right.
  function automatic logic [31:0] crypt_rotr(input logic [31:0] x, input logic [4:0] amt);
    logic [5:0] inv;
    inv = 6'd32 - {1'b0, amt};
    return (x >> amt) | (x << inv);
  endfunction

  // Encrypt round r: d = rotl(d ^ k_r, rot) + k_r, where k_r = rotl(key, r).
  function automatic logic [31:0] crypt_enc_round(input logic [31:0] data,
                                                  input logic [31:0] key,
                                                  input logic [4:0]  r,
                                                  input logic [4:0]  rot);
    logic [31:0] k;
    k = crypt_rotl(key, r);
    return crypt_rotl(data ^ k, rot) + k;
  endfunction

  // Decrypt round r: d = rotr(d - k_r, rot) ^ k_r, the inverse of crypt_enc_round.
  function automatic logic [31:0] crypt_dec_round(input logic [31:0] data,
                                                  input logic [31:0] key,
                                                  input logic [4:0]  r,
                                                  input logic [4:0]  rot);
    logic [31:0] k;
    k = crypt_rotl(key, r);
    return crypt_rotr(data - k, rot) ^ k;
  endfunction

endpackage

// File: rtl/ibex_load_decrypt.sv
// Load-side memory decryptor.
// Sits between the data-bus response and the LSU. Responses from encrypted
// regions are decrypted one round per cycle, starting at round NumRounds-1 and
// ending at round 0. Plain and errored responses pass through unmodified.
// Single-entry engine: one word in flight at a time.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   flush_i                           drop the in-flight word, return to idle
//   in_valid_i / in_ready_o           bus response handshake
//   in_rdata_i, in_err_i, in_encrypt_i  response data, bus error, PMP encrypt bit
//   key_i                             memory encryption key, captured at accept
//   out_valid_o / out_ready_i         LSU handshake
//   out_rdata_o, out_err_o            plaintext data and error passthrough
module ibex_load_decrypt
  import ibex_load_decrypt_pkg::*;
#(
  parameter int unsigned NumRounds = MEM_CRYPT_ROUNDS,
  parameter int unsigned RotAmt    = MEM_CRYPT_ROT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  input  logic        in_encrypt_i,
  input  logic [31:0] key_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic        out_err_o
);

  localparam int unsigned CntW = (NumRounds > 1) ? $clog2(NumRounds) : 1;

  dec_state_e      state_r, state_s;
  logic [CntW-1:0] cnt_r, cnt_s;
  logic [31:0]     data_r, data_s;
  logic [31:0]     key_r, key_s;
  logic            err_r, err_s;
  logic            out_valid_r;
  logic            accept_s;
  logic [31:0]     dec_data_s;

  assign in_ready_o  = (state_r == DEC_IDLE) & ~flush_i;
  assign out_valid_o = out_valid_r;
  assign out_rdata_o = data_r;
  assign out_err_o   = err_r;

  // One decrypt round on the data register, using the current round index.
  assign dec_data_s = crypt_dec_round(data_r, key_r, 5'(cnt_r), 5'(RotAmt));

  // Next-state logic and acceptance; flush overrides everything.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    if (flush_i) begin
      state_s = DEC_IDLE;
    end else begin
      case (state_r)
        DEC_IDLE: begin
          if (in_valid_i) begin
            accept_s = 1'b1;
            if (in_encrypt_i && !in_err_i) begin
              state_s = DEC_ROUND;
            end else begin
              state_s = DEC_DONE;
            end
          end else begin
            state_s = DEC_IDLE;
          end
        end
        DEC_ROUND: begin
          if (cnt_r == {CntW{1'b0}}) begin
            state_s = DEC_DONE;
          end else begin
            state_s = DEC_ROUND;
          end
        end
        DEC_DONE: begin
          // No re-accept in the same cycle: in_ready_o is low while in DONE.
          if (out_ready_i) begin
            state_s = DEC_IDLE;
          end else begin
            state_s = DEC_DONE;
          end
        end
        default: begin
          state_s = DEC_IDLE;
        end
      endcase
    end
  end

  // Datapath next values: load on accept, step one round while in ROUND.
  always_comb begin
    data_s = data_r;
    key_s  = key_r;
    err_s  = err_r;
    cnt_s  = cnt_r;
    if (accept_s) begin
      data_s = in_rdata_i;
      key_s  = key_i;
      err_s  = in_err_i;
      cnt_s  = CntW'(NumRounds - 1);
    end else if ((state_r == DEC_ROUND) && !flush_i) begin
      data_s = dec_data_s;
      // Counter parks at zero on the final round; the FSM exits instead of wrapping.
      if (cnt_r == {CntW{1'b0}}) begin
        cnt_s = cnt_r;
      end else begin
        cnt_s = cnt_r - CntW'(1'b1);
      end
    end else begin
      data_s = data_r;
    end
  end

  // State, datapath and output-valid registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= DEC_IDLE;
      cnt_r       <= {CntW{1'b0}};
      data_r      <= 32'h0000_0000;
      key_r       <= 32'h0000_0000;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      data_r      <= data_s;
      key_r       <= key_s;
      err_r       <= err_s;
      out_valid_r <= (state_s == DEC_DONE);
    end
  end

endmodule
